// File: rtl/alu_seq.sv
// Operand/control sequencer for the 8-bit ALU: loads A then B, fires one EXEC cycle,
// captures result and Z/N/C/DZ flags. Define ALU_SEQ_CHECK_EN to add the result self-check.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_bus_in,
    input  logic             start,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_data_bus,
    output logic [WIDTH-1:0] b_data_bus,
    output logic [7:0]       opr,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_dz,
    output logic             alu_err
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_LOAD_B, S_EXEC, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   sum_lo;
    logic [2*WIDTH-1:0] prod_w;
    logic               carry;
    logic               div_zero;

    assign div_zero = (op_q == OP_DIV) && (data_bus_in == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = div_zero ? S_DONE : S_EXEC;
            S_EXEC:   state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign alu_en = (state == S_EXEC);

    // CMP has no ALU opcode of its own; it borrows SUB and discards the result.
    always_comb begin
        opr = 8'h00;
        if (state == S_EXEC)
            opr = (op_q == OP_CMP) ? 8'h02 : (8'h01 << op_q);
    end

    assign sum_lo = a_data_bus + b_data_bus;
    assign prod_w = {{WIDTH{1'b0}}, a_data_bus} * {{WIDTH{1'b0}}, b_data_bus};

    always_comb begin
        carry = 1'b0;
        case (op_q)
            OP_ADD:         carry = (sum_lo < a_data_bus);
            OP_SUB, OP_CMP: carry = (a_data_bus < b_data_bus);
            OP_MUL:         carry = (prod_w > {{WIDTH{1'b0}}, {WIDTH{1'b1}}});
            default:        carry = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_result;

    always_comb begin
        exp_result = '0;
        case (op_q)
            OP_ADD:         exp_result = sum_lo;
            OP_SUB, OP_CMP: exp_result = a_data_bus - b_data_bus;
            OP_MUL:         exp_result = prod_w[WIDTH-1:0];
            OP_DIV:         exp_result = (b_data_bus != '0) ? a_data_bus / b_data_bus : '0;
            3'd4:           exp_result = a_data_bus & b_data_bus;
            3'd5:           exp_result = a_data_bus | b_data_bus;
            3'd6:           exp_result = a_data_bus ^ b_data_bus;
            default:        exp_result = '0;
        endcase
    end

    // Case inequality so an X/Z result from the ALU also trips the error.
    always_ff @(posedge clk) begin
        if (!rst_n)
            alu_err <= 1'b0;
        else if (state == S_EXEC && alu_result !== exp_result)
            alu_err <= 1'b1;
    end
`else
    assign alu_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_data_bus <= '0;
            b_data_bus <= '0;
            result     <= '0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            flag_c     <= 1'b0;
            flag_dz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_data_bus <= data_bus_in;
                        op_q       <= op;
                    end
                end
                S_LOAD_B: begin
                    b_data_bus <= data_bus_in;
                    if (div_zero) flag_dz <= 1'b1;
                end
                S_EXEC: begin
                    if (op_q != OP_CMP) result <= alu_result;
                    flag_z  <= (alu_result == '0);
                    flag_n  <= alu_result[WIDTH-1];
                    flag_c  <= carry;
                    flag_dz <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a behavioural ALU answers the sequencer, expected
// result/flags/latency are queued at start and checked when done pulses.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_bus_in = 8'h00;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic       busy, done, alu_en;
    logic [7:0] a_data_bus, b_data_bus, opr, result;
    logic [7:0] alu_result;
    logic       flag_z, flag_n, flag_c, flag_dz, alu_err;
    logic       alu_bad = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .data_bus_in(data_bus_in), .start(start), .op(op),
        .busy(busy), .done(done), .a_data_bus(a_data_bus), .b_data_bus(b_data_bus),
        .opr(opr), .alu_en(alu_en), .alu_result(alu_result), .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_dz(flag_dz),
        .alu_err(alu_err)
    );

    // behavioural ALU keyed on the one-hot opcode
    always_comb begin
        alu_result = 8'h00;
        case (opr)
            8'h01: alu_result = a_data_bus + b_data_bus;
            8'h02: alu_result = a_data_bus - b_data_bus;
            8'h04: alu_result = a_data_bus * b_data_bus;
            8'h08: alu_result = (b_data_bus != 0) ? a_data_bus / b_data_bus : 8'h00;
            8'h10: alu_result = a_data_bus & b_data_bus;
            8'h20: alu_result = a_data_bus | b_data_bus;
            8'h40: alu_result = a_data_bus ^ b_data_bus;
            default: alu_result = 8'h00;
        endcase
        if (alu_bad) alu_result = 8'hAA;
    end

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        int         lat;
        logic [7:0] opr;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] m_res = 8'h00;
    logic [3:0] m_flg = 4'h0;   // {z, n, c, dz}
    logic       m_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] opr_of(input logic [2:0] o);
        case (o)
            3'd0: return 8'h01;
            3'd1: return 8'h02;
            3'd2: return 8'h04;
            3'd3: return 8'h08;
            3'd4: return 8'h10;
            3'd5: return 8'h20;
            3'd6: return 8'h40;
            default: return 8'h02;
        endcase
    endfunction

    task automatic push_exp(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [7:0]  r;
        logic        c;
        logic [15:0] p;
        r = 8'h00;
        c = 1'b0;
        if (o == 3'd3 && b == 8'h00) begin
            m_flg[0] = 1'b1;
            e.lat = 2;
            e.opr = 8'h00;
        end else begin
            case (o)
                3'd0: begin r = a + b; c = ({1'b0, a} + {1'b0, b}) > 9'd255; end
                3'd1, 3'd7: begin r = a - b; c = (a < b); end
                3'd2: begin p = {8'h00, a} * {8'h00, b}; r = p[7:0]; c = (p > 16'd255); end
                3'd3: r = a / b;
                3'd4: r = a & b;
                3'd5: r = a | b;
                default: r = a ^ b;
            endcase
            if (alu_bad) begin
                r = 8'hAA;
`ifdef ALU_SEQ_CHECK_EN
                m_err = 1'b1;
`endif
            end
            if (o != 3'd7) m_res = r;
            m_flg = {r == 8'h00, r[7], c, 1'b0};
            e.lat = 3;
            e.opr = opr_of(o);
        end
        e.res = m_res;
        e.flg = m_flg;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b1;
        op = 3'd0;
        data_bus_in = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {busy, done, alu_en, a_data_bus, b_data_bus, opr, result,
                         flag_z, flag_n, flag_c, flag_dz, alu_err}, 64'd0);
        rst_n = 1'b1;
        start = 1'b0;
        m_res = 8'h00;
        m_flg = 4'h0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_idle", {busy, done}, 64'd0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic hold);
        exp_t       e;
        int         en_cyc, en_cnt, done_cyc;
        logic [7:0] opr_seen;
        logic       opr_leak, got;
        @(posedge clk);
        #1;
        chk("idle_state", {busy, done}, 64'd0);
        start = 1'b1;
        op = o;
        data_bus_in = a;
        push_exp(o, a, b);
        @(posedge clk);
        #1;
        start = hold;
        data_bus_in = b;
        if (hold) op = o ^ 3'd4;
        en_cyc = -1;
        en_cnt = 0;
        done_cyc = 0;
        opr_seen = 8'h00;
        opr_leak = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
                data_bus_in = 8'($urandom);
            end
            chk("busy", busy, 1);
            if (alu_en) begin
                en_cnt++;
                en_cyc = c;
                opr_seen = opr;
            end else if (opr != 8'h00) begin
                opr_leak = 1'b1;
            end
            if (done) begin
                got = 1'b1;
                done_cyc = c;
                break;
            end
        end
        chk("timeout", got, 1);
        if (got) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("flags", {flag_z, flag_n, flag_c, flag_dz}, e.flg);
                chk("done_cyc", done_cyc, e.lat);
                chk("en_cnt", en_cnt, (e.lat == 3) ? 1 : 0);
                chk("en_cyc", en_cyc, (e.lat == 3) ? 2 : -1);
                chk("opr", opr_seen, e.opr);
                chk("a_bus", a_data_bus, a);
                chk("b_bus", b_data_bus, b);
            end
        end
        chk("opr_leak", opr_leak, 0);
        chk("alu_err", alu_err, m_err);
    endtask

    initial begin
        do_reset();

        run_op(3'd0, 8'hF0, 8'h20, 1'b0);   // ADD overflow
        run_op(3'd5, 8'h50, 8'h05, 1'b0);   // preload 0x55
        run_op(3'd7, 8'h05, 8'h09, 1'b0);   // CMP keeps result
        run_op(3'd3, 8'h40, 8'h00, 1'b0);   // DIV by zero
        run_op(3'd4, 8'h0F, 8'hF0, 1'b0);   // AND -> zero, clears DZ
        run_op(3'd2, 8'h10, 8'h10, 1'b1);   // MUL overflow, start held high
        run_op(3'd1, 8'h03, 8'h05, 1'b0);   // back-to-back SUB borrow
        run_op(3'd6, 8'hC3, 8'h3C, 1'b0);
        run_op(3'd3, 8'h64, 8'h07, 1'b0);

        // reset during EXEC of an ADD
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 3'd0;
        data_bus_in = 8'h33;
        @(posedge clk);
        #1;
        start = 1'b0;
        data_bus_in = 8'h44;
        @(posedge clk);
        #1;
        chk("midrst_exec", alu_en, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_res = 8'h00;
        m_flg = 4'h0;
        m_err = 1'b0;
        chk("midrst_outs", {busy, done, result, flag_z, flag_n, flag_c, flag_dz}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_nodone", {busy, done}, 64'd0);
        end

        // corrupted ALU output; the self-check build must flag it and hold the error
        alu_bad = 1'b1;
        run_op(3'd0, 8'h01, 8'h01, 1'b0);
        alu_bad = 1'b0;
        run_op(3'd5, 8'h0F, 8'h30, 1'b0);
        do_reset();
        run_op(3'd6, 8'hFF, 8'h0F, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Operand and control sequencer that sits directly upstream of the 8-bit ALU.
- Loads operand A, then operand B, from the shared data bus over two cycles.
- Drives the ALU's one-hot opcode and enable for exactly one cycle, then captures the result.
- Maintains a result register and status flags (Z, N, C, DZ); implements CMP (which the ALU lacks) and guards divide-by-zero.

Parameters:
- WIDTH, 8, data path width; fixed at 8 for this CPU, other values unsupported.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- data_bus_in  input  8  shared data bus; A sampled in start cycle, B in following cycle
- start  input  1  request operation; accepted only in IDLE
- op  input  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 CMP; sampled with start
- busy  output  1  high in LOAD_B, EXEC, DONE
- done  output  1  one-cycle completion pulse
- a_data_bus  output  8  latched operand A to ALU
- b_data_bus  output  8  latched operand B to ALU
- opr  output  8  one-hot ALU opcode, 0 outside EXEC
- alu_en  output  1  ALU enable, high only in EXEC
- alu_result  input  8  ALU out_data_bus (combinational, valid during EXEC)
- result  output  8  result register
- flag_z, flag_n, flag_c, flag_dz  output  1 each  status flags
- alu_err  output  1  sticky self-check error (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; all outputs 0, including a_data_bus, b_data_bus, result and every flag. Reset mid-operation aborts the operation with no done pulse.
- IDLE: if start=1, latch A<=data_bus_in and op, then go to LOAD_B. start=0 stays in IDLE. start is ignored in every other state.
- LOAD_B: latch B<=data_bus_in.
  - If op=DIV and data_bus_in==0: set flag_dz=1, leave result/Z/N/C unchanged, go to DONE.
  - Otherwise go to EXEC.
- EXEC: alu_en=1; opr = 2**op for op 0..6 (0x01 ADD, 0x02 SUB, 0x04 MUL, 0x08 DIV, 0x10 AND, 0x20 OR, 0x40 XOR). For CMP, opr=0x02 (SUB). At the closing edge, alu_result is captured:
  - result<=alu_result, except CMP, which leaves result unchanged.
  - flag_z<=(alu_result==0); flag_n<=alu_result[7].
  - flag_c: ADD = bit 8 of 9-bit A+B; SUB/CMP = (A<B) unsigned; MUL = (upper byte of 16-bit A*B != 0); DIV/AND/OR/XOR = 0.
  - flag_dz<=0.
  - Next state DONE.
- DONE: done=1 for this cycle only; next state IDLE.
- Latency:
  - Normal op: start at cycle 0, alu_en in cycle 2, done in cycle 3. Next start is accepted in cycle 4.
  - DIV-by-zero: done in cycle 2, ALU never enabled.
- Timing of outputs:
  - a_data_bus/b_data_bus hold latched values until the next load.
  - result and flags are stable from the done cycle until the next EXEC/DZ update.
- All arithmetic is unsigned and modulo 256; the ALU's 8-bit truncation of MUL is accepted, with overflow reported via flag_c.
- opr is never non-zero while alu_en=0, so the ALU's tri-state output is undriven outside EXEC.

Optional Feature:
- Macro: ALU_SEQ_CHECK_EN.
- Defined:
  - In EXEC, compute the expected 8-bit result internally from A, B and op (CMP checked as SUB).
  - If alu_result differs, or contains X/Z in simulation, set alu_err=1.
  - alu_err is sticky until reset.
- Undefined: no checker logic; alu_err tied 0.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with start=1 -> all outputs 0, busy=0, no done.
- ADD overflow: start, op=0, A=0xF0, B=0x20 -> opr=0x01 and alu_en high in cycle 2 only; done cycle 3; result=0x10, Z=0, N=0, C=1.
- CMP: result preloaded 0x55; op=7, A=0x05, B=0x09 -> opr=0x02; result stays 0x55; Z=0, N=1 (0xFC), C=1.
- DIV by zero: op=3, A=0x40, B=0x00 -> alu_en never high, done in cycle 2, DZ=1, result and Z/N/C unchanged. A following op=4 with A=0x0F, B=0xF0 -> result=0x00, Z=1, DZ=0.
- MUL and back-to-back: op=2, A=0x10, B=0x10 -> result=0x00, Z=1, C=1. start held high throughout -> second operation begins only in cycle 4; start during busy ignored.
- Reset mid-op: rst_n=0 in cycle 2 of an ADD -> no done, result=0, state IDLE. With ALU_SEQ_CHECK_EN defined and alu_result forced to 0xAA on A=1, B=1 ADD -> alu_err=1, held until reset.
